// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array stream block.
//   state_t   : sequencing states of the array controller
//   DEF_*     : default geometry and widths
//   sat_add() : width-generic signed add with saturate/wrap and overflow flag
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  localparam int DEF_ROWS     = 4;
  localparam int DEF_COLS     = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ACC_W    = 20;

  // Operands are carried sign-extended in MAXW bits; acc_w selects the
  // signed range the result must fit. Callers keep the low acc_w bits.
  localparam int MAXW = 64;

  typedef struct packed {
    logic                   ovf;
    logic signed [MAXW-1:0] sum;
  } add_res_t;

  function automatic add_res_t sat_add(input logic signed [MAXW-1:0] a,
                                       input logic signed [MAXW-1:0] b,
                                       input int                     acc_w,
                                       input logic                   sat);
    logic signed [MAXW:0] s, hi, lo;
    add_res_t             r;
    s     = {a[MAXW-1], a} + {b[MAXW-1], b};
    hi    = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo    = -hi - 65'sd1;
    r.ovf = (s > hi) || (s < lo);
    if (r.ovf && sat) r.sum = (s > hi) ? hi[MAXW-1:0] : lo[MAXW-1:0];
    else              r.sum = s[MAXW-1:0];  // wrap falls out of truncation
    return r;
  endfunction

endpackage

// File: rtl/mac_array_stream_if.sv
// Bus bundle for mac_array_stream: weight write port, activation input
// stream and result output stream.
//   slave  : array side (mac_array_stream)
//   master : producer/consumer side
interface mac_array_stream_if #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int DEPTH    = 32,
  parameter int ACC_W    = 20
);
  localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1;

  logic                     wr_en, wr_ready;
  logic [CW-1:0]            wr_col;
  logic [AW-1:0]            wr_addr;
  logic [WEIGHT_W-1:0]      wr_data;
  logic                     in_valid, in_ready, in_last, sat_en;
  logic [ROWS*DATA_W-1:0]   in_data;
  logic [AW-1:0]            in_waddr;
  logic                     out_valid, out_ready, out_last, ovf;
  logic [COLS*ACC_W-1:0]    out_data;
  logic [RW-1:0]            out_row;

  modport slave (
    input  wr_en, wr_col, wr_addr, wr_data,
           in_valid, in_data, in_waddr, in_last, sat_en, out_ready,
    output wr_ready, in_ready, out_valid, out_data, out_row, out_last, ovf
  );

  modport master (
    output wr_en, wr_col, wr_addr, wr_data,
           in_valid, in_data, in_waddr, in_last, sat_en, out_ready,
    input  wr_ready, in_ready, out_valid, out_data, out_row, out_last, ovf
  );
endinterface

// File: rtl/mac_pe.sv
// One signed MAC cell: acc += sext(data*weight) when i_en, with saturate
// or wrap per i_sat, sticky o_ovf, and synchronous clear via i_clr.
//   i_en/i_sat/i_clr : stage-2 strobe, saturate select, clear
//   i_data/i_weight  : registered operands
//   o_acc/o_ovf      : accumulator and sticky overflow
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20
) (
  input  logic                       Clk,
  input  logic                       resetN,
  input  logic                       i_en,
  input  logic                       i_sat,
  input  logic                       i_clr,
  input  logic signed [DATA_W-1:0]   i_data,
  input  logic signed [WEIGHT_W-1:0] i_weight,
  output logic signed [ACC_W-1:0]    o_acc,
  output logic                       o_ovf
);
  localparam int PW = DATA_W + WEIGHT_W;

  logic signed [PW-1:0] w_prod;
  add_res_t             w_res;
  logic                 w_unused_hi;

  assign w_prod      = PW'(i_data) * PW'(i_weight);
  assign w_res       = sat_add(MAXW'(o_acc), MAXW'(w_prod), ACC_W, i_sat);
  assign w_unused_hi = ^w_res.sum[MAXW-1:ACC_W];

  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) begin
      o_acc <= '0;
      o_ovf <= 1'b0;
    end else if (i_clr) begin
      o_acc <= '0;
      o_ovf <= 1'b0;
    end else if (i_en) begin
      o_acc <= w_res.sum[ACC_W-1:0];
      o_ovf <= o_ovf | w_res.ovf;
    end
  end
endmodule

// File: rtl/mac_array_stream.sv
// ROWS x COLS signed MAC array with per-column weight banks.
//   Clk/resetN : clock, async active-low reset
//   s_if       : weight write, activation stream in, result rows out
// Flow: IDLE (writes + first beat) -> ACCUM -> FLUSH (last beat lands in
// the accumulators) -> DRAIN (one row per out handshake) -> IDLE.
module mac_array_stream
  import mac_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic          Clk,
  input  logic          resetN,
  mac_array_stream_if.slave s_if
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t r_state, w_nxt;
  logic   w_in_ready, w_wr_ready, w_out_valid;
  logic   w_in_hs, w_wr_hs, w_clr;
  logic [RW-1:0] r_row;

  logic [WEIGHT_W-1:0] r_bank [COLS][DEPTH];

  logic                            r_s1_vld, r_s1_sat;
  logic [ROWS-1:0][DATA_W-1:0]     r_s1_data;
  logic [COLS-1:0][WEIGHT_W-1:0]   r_s1_w;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] w_acc;
  logic [ROWS-1:0][COLS-1:0]       w_ovf;

  assign w_in_hs = s_if.in_valid & w_in_ready;
  assign w_wr_hs = s_if.wr_en & w_wr_ready;
  // Final row handshake empties the array for the next accumulation.
  assign w_clr   = (r_state == DRAIN) & s_if.out_ready & (r_row == RW'(ROWS-1));

  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_in_ready  = 1'b0;
    w_wr_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_wr_ready = 1'b1;
        if (s_if.in_valid) w_nxt = s_if.in_last ? FLUSH : ACCUM;
      end
      ACCUM: begin
        w_in_ready = 1'b1;
        if (s_if.in_valid && s_if.in_last) w_nxt = FLUSH;
      end
      FLUSH: w_nxt = DRAIN;
      DRAIN: begin
        w_out_valid = 1'b1;
        if (w_clr) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) r_row <= '0;
    else if (r_state == DRAIN && s_if.out_ready) r_row <= w_clr ? '0 : r_row + 1'b1;
  end

  // Bank read for stage 1 shares the edge with any write, so a same-address
  // write lands after the beat has captured the old weight.
  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) begin
      for (int c = 0; c < COLS; c++)
        for (int a = 0; a < DEPTH; a++) r_bank[c][a] <= '0;
    end else if (w_wr_hs) begin
      r_bank[s_if.wr_col][s_if.wr_addr] <= s_if.wr_data;
    end
  end

  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_vld  <= 1'b0;
      r_s1_sat  <= 1'b0;
      r_s1_data <= '0;
      r_s1_w    <= '0;
    end else begin
      r_s1_vld <= w_in_hs;
      if (w_in_hs) begin
        r_s1_sat <= s_if.sat_en;
        for (int r = 0; r < ROWS; r++) r_s1_data[r] <= s_if.in_data[r*DATA_W +: DATA_W];
        for (int c = 0; c < COLS; c++) r_s1_w[c]    <= r_bank[c][s_if.in_waddr];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      mac_pe #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) u_pe (
        .Clk      (Clk),
        .resetN   (resetN),
        .i_en     (r_s1_vld),
        .i_sat    (r_s1_sat),
        .i_clr    (w_clr),
        .i_data   (r_s1_data[r]),
        .i_weight (r_s1_w[c]),
        .o_acc    (w_acc[r][c]),
        .o_ovf    (w_ovf[r][c])
      );
    end
    if (r == 0) begin : g_out
      for (genvar c = 0; c < COLS; c++) begin : g_col
        assign s_if.out_data[c*ACC_W +: ACC_W] = w_out_valid ? w_acc[r_row][c] : '0;
      end
    end
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.wr_ready  = w_wr_ready;
  assign s_if.out_valid = w_out_valid;
  assign s_if.out_row   = r_row;
  assign s_if.out_last  = w_out_valid & (r_row == RW'(ROWS-1));
  assign s_if.ovf       = |w_ovf;
endmodule

// File: tb/tb_mac_array_stream.sv
module tb_mac_array_stream;
  localparam int ROWS = 4, COLS = 4, DATA_W = 8, WEIGHT_W = 8, DEPTH = 32, ACC_W = 17;
  localparam int OW = COLS*ACC_W;
  localparam int CW = 2, AW = 5;
  localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));
  localparam longint AMOD = longint'(1) <<< ACC_W;

  typedef int row_t[ROWS];
  typedef struct { logic [OW-1:0] data; int row; bit last; bit ovf; } exp_t;

  logic Clk = 1'b0, resetN = 1'b0;
  always #5 Clk = ~Clk;

  mac_array_stream_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                        .DEPTH(DEPTH), .ACC_W(ACC_W)) bus();
  mac_array_stream #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                     .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (.Clk(Clk), .resetN(resetN), .s_if(bus.slave));

  exp_t   sb[$];
  int     n_cmp = 0, n_bad = 0;
  int     mbank[COLS][DEPTH];
  longint macc[ROWS][COLS];
  bit     mov;
  bit     bp_manual = 1'b1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic row_t fill(input int v);
    row_t d;
    for (int r = 0; r < ROWS; r++) d[r] = v;
    return d;
  endfunction

  function automatic row_t rnd_row();
    row_t d;
    for (int r = 0; r < ROWS; r++) d[r] = int'($urandom_range(0, 255)) - 128;
    return d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) for (int a = 0; a < DEPTH; a++) mbank[c][a] = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) macc[r][c] = 0;
    mov = 1'b0;
    sb.delete();
  endtask

  // Reference: each beat adds data[r]*w[c] into every cell, with the
  // result range limited to signed ACC_W bits; the last beat yields ROWS rows.
  task automatic model_beat(input row_t d, input int a, input bit last, input bit sat);
    longint s;
    exp_t   e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        s = macc[r][c] + longint'(d[r] * mbank[c][a]);
        if (s > AMAX) begin mov = 1'b1; s = sat ? AMAX : s - AMOD; end
        else if (s < AMIN) begin mov = 1'b1; s = sat ? AMIN : s + AMOD; end
        macc[r][c] = s;
      end
    if (last) begin
      for (int r = 0; r < ROWS; r++) begin
        e.data = '0;
        for (int c = 0; c < COLS; c++) e.data[c*ACC_W +: ACC_W] = ACC_W'(macc[r][c]);
        e.row = r; e.last = (r == ROWS-1); e.ovf = mov;
        sb.push_back(e);
      end
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) macc[r][c] = 0;
      mov = 1'b0;
    end
  endtask

  // Drives one cycle of inputs just after the rising edge; the handshake
  // completes on the following edge, so the model is updated here.
  task automatic step(input bit we, input int wc, input int wa, input int wd,
                      input bit iv, input row_t d, input int ia, input bit il, input bit is_,
                      output bit wok, output bit iok);
    @(posedge Clk); #1;
    bus.wr_en = we; bus.wr_col = CW'(wc); bus.wr_addr = AW'(wa); bus.wr_data = WEIGHT_W'(wd);
    bus.in_valid = iv; bus.in_waddr = AW'(ia); bus.in_last = il; bus.sat_en = is_;
    for (int r = 0; r < ROWS; r++) bus.in_data[r*DATA_W +: DATA_W] = DATA_W'(d[r]);
    wok = we && bus.wr_ready;
    iok = iv && bus.in_ready;
    if (iok) model_beat(d, ia, il, is_);
    if (wok) mbank[wc][wa] = wd;
  endtask

  task automatic idle();
    bit wok, iok;
    step(0, 0, 0, 0, 0, fill(0), 0, 0, 0, wok, iok);
  endtask

  task automatic wr(input int c, input int a, input int v);
    bit wok, iok;
    step(1, c, a, v, 0, fill(0), 0, 0, 0, wok, iok);
    chk("wr_ready_idle", wok, 1);
  endtask

  task automatic beat(input row_t d, input int a, input bit last, input bit sat);
    bit wok, iok;
    step(0, 0, 0, 0, 1, d, a, last, sat, wok, iok);
    chk("in_ready", iok, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      idle();
      if (bus.in_ready && !bus.out_valid) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: array still busy, expected IDLE");
    end
    chk("ovf_cleared", bus.ovf, 0);
  endtask

  // Randomised consumer backpressure unless a test takes manual control.
  initial forever begin
    @(posedge Clk); #1;
    if (!bp_manual) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare every accepted output row against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (resetN && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_empty: row %0d presented, expected no output", bus.out_row);
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_row",  bus.out_row,  e.row);
        chk("out_last", bus.out_last, e.last);
        chk("ovf_row",  bus.ovf,      e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t d;
    bit   wok, iok;
    bus.wr_en = 0; bus.wr_col = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_waddr = '0; bus.in_last = 0; bus.sat_en = 0;
    bus.out_ready = 1;
    model_reset();
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_row",   bus.out_row,   0);
    chk("rst_out_last",  bus.out_last,  0);
    chk("rst_ovf",       bus.ovf,       0);
    chk("rst_in_ready",  bus.in_ready,  1);
    resetN = 1'b1;

    // Weight load, single beat, 2-cycle latency.
    for (int c = 0; c < COLS; c++) wr(c, 0, c+1);
    bus.out_ready = 0;
    d = '{1, 2, 3, 4};
    beat(d, 0, 1, 0);
    idle(); chk("lat_flush", bus.out_valid, 0);
    idle(); chk("lat_drain", bus.out_valid, 1);
    chk("lat_row0", bus.out_row, 0);
    bus.out_ready = 1;
    wait_idle();

    // Signed multi-beat, with backpressure held on row 1.
    wr(0, 1, -128); wr(1, 1, 127);
    beat(fill(-128), 1, 0, 0);
    beat(fill(-128), 1, 1, 0);
    idle(); idle(); idle();
    bus.out_ready = 0;
    chk("bp_row", bus.out_row, 1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("bp_hold_row", bus.out_row, 1);
      chk("bp_hold_data", bus.out_data, sb[0].data);
    end
    bus.out_ready = 1;
    wait_idle();

    // Saturating then wrapping accumulate of 5 x 127*127.
    bp_manual = 1'b0;
    for (int c = 0; c < COLS; c++) wr(c, 2, 127);
    for (int s = 1; s >= 0; s--) begin
      for (int b = 0; b < 5; b++) beat(fill(127), 2, b == 4, s[0]);
      idle(); idle();
      chk("ovf_set", bus.ovf, 1);
      wait_idle();
    end

    // Writes are refused while accumulating.
    for (int c = 0; c < COLS; c++) wr(c, 5, 10 + c);
    beat(rnd_row(), 5, 0, 0);
    step(1, 0, 5, 99, 0, fill(0), 0, 0, 0, wok, iok);
    chk("wr_blocked", bus.wr_ready, 0);
    beat(rnd_row(), 5, 1, 0);
    wait_idle();
    beat(rnd_row(), 5, 1, 0);
    wait_idle();

    // Same-cycle write and beat to one address: beat sees the old weight.
    step(1, 1, 0, -7, 1, rnd_row(), 0, 1, 0, wok, iok);
    chk("rbw_wr", wok, 1);
    chk("rbw_in", iok, 1);
    wait_idle();
    beat(fill(3), 0, 1, 0);
    wait_idle();

    // Randomised runs with gaps and per-beat saturation mode.
    for (int run = 0; run < 6; run++) begin
      int nb;
      for (int k = 0; k < 3; k++)
        wr($urandom_range(0, COLS-1), $urandom_range(0, 7), int'($urandom_range(0, 255)) - 128);
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) idle();
        beat(rnd_row(), $urandom_range(0, 7), b == nb-1, $urandom_range(0, 1));
      end
      wait_idle();
    end

    // Asynchronous reset in the middle of an accumulation.
    bp_manual = 1'b1; bus.out_ready = 1;
    for (int c = 0; c < COLS; c++) wr(c, 3, 5);
    beat(fill(9), 3, 0, 0);
    beat(fill(9), 3, 0, 0);
    @(posedge Clk); #3;
    resetN = 1'b0;
    bus.in_valid = 0; bus.wr_en = 0;
    #1;
    chk("mrst_in_ready",  bus.in_ready,  1);
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_ovf",       bus.ovf,       0);
    model_reset();
    #10;
    resetN = 1'b1;
    beat(fill(9), 3, 1, 0);
    wait_idle();

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
